// File: rtl/stm_focus_writer_pkg.sv
// Shared definitions for the focus-STM writer and the stm focus reader.
// A focus entry is 64 bits split into four 16-bit BRAM words:
//   {2'b00, intensity[7:0], z[17:0], y[17:0], x[17:0]}
// pack_focus_word() is the single source of truth for that layout.
package stm_focus_writer_pkg;

  localparam int unsigned STM_FOCUS_WORDS   = 4;
  localparam int unsigned STM_FOCUS_COORD_W = 18;
  localparam int unsigned STM_IDX_W         = 13;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWr0,
    StWr1,
    StWr2,
    StWr3,
    StFinish
  } state_e;

  function automatic logic [15:0] pack_focus_word(
    input logic [STM_FOCUS_COORD_W-1:0] x,
    input logic [STM_FOCUS_COORD_W-1:0] y,
    input logic [STM_FOCUS_COORD_W-1:0] z,
    input logic [7:0]                   intensity,
    input logic [1:0]                   word
  );
    logic [15:0] w;
    case (word)
      2'd0:    w = x[15:0];
      2'd1:    w = {y[13:0], x[17:16]};
      2'd2:    w = {z[11:0], y[17:14]};
      default: w = {2'b00, intensity, z[17:12]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/stm_focus_writer.sv
// Packs a stream of focus points into 64-bit focus-STM entries and writes them
// 16 bits at a time into the STM BRAM segment.
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, SEGMENT,   session start (ignored while BUSY), target segment and
//   NUM_FOCI          foci per pattern, latched at an accepted START
//   FOCUS_*           valid/ready focus stream, LAST marks the final focus
//   MEM_*             BRAM write port, MEM_ADDR = {pattern_idx, focus_idx, word}
//   BUSY, DONE        session in progress / one-cycle end pulse
//   CYCLE             patterns written minus one, valid at DONE
//   ERROR             sticky, cleared by the next accepted START
// All outputs come straight from flops.
module stm_focus_writer
  import stm_focus_writer_pkg::*;
#(
  parameter int unsigned MAX_FOCI = 8,
  parameter int unsigned IDX_W    = STM_IDX_W,
  localparam int unsigned FW      = $clog2(MAX_FOCI),
  localparam int unsigned AW      = IDX_W + FW + 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          SEGMENT,
  input  logic [3:0]    NUM_FOCI,
  input  logic          FOCUS_VALID,
  output logic          FOCUS_READY,
  input  logic [17:0]   FOCUS_X,
  input  logic [17:0]   FOCUS_Y,
  input  logic [17:0]   FOCUS_Z,
  input  logic [7:0]    FOCUS_INTENSITY,
  input  logic          FOCUS_LAST,
  output logic          MEM_WE,
  output logic          MEM_SEGMENT,
  output logic [AW-1:0] MEM_ADDR,
  output logic [15:0]   MEM_DIN,
  output logic          BUSY,
  output logic          DONE,
  output logic [IDX_W-1:0] CYCLE,
  output logic          ERROR
);

  state_e state_q, state_d;

  logic             seg_q;
  logic [3:0]       nfoci_q;
  logic [FW-1:0]    fidx_q, fidx_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic [17:0]      x_q, y_q, z_q;
  logic [7:0]       int_q;
  logic             last_q;

  logic             we_d, mseg_d, busy_d, done_d, error_d, ready_d;
  logic [AW-1:0]    addr_d;
  logic [15:0]      din_d;
  logic [IDX_W-1:0] cycle_d;

  logic       start_ok, start_bad, accept, at_end;
  logic [1:0] word_d;
  logic [17:0] px, py, pz;
  logic [7:0]  pint;

  assign start_ok  = (state_q == StIdle) && START &&
                     (NUM_FOCI != 4'd0) && (32'(NUM_FOCI) <= MAX_FOCI);
  assign start_bad = (state_q == StIdle) && START && !start_ok;
  assign accept    = (state_q == StAccept) && FOCUS_VALID;
  assign at_end    = (4'(fidx_q) == nfoci_q - 4'd1);

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    pidx_d  = pidx_q;
    error_d = ERROR;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StAccept;
          fidx_d  = '0;
          pidx_d  = '0;
          error_d = 1'b0;
        end else if (start_bad) begin
          error_d = 1'b1;
        end
      end
      StAccept: if (FOCUS_VALID) state_d = StWr0;
      StWr0:    state_d = StWr1;
      StWr1:    state_d = StWr2;
      StWr2:    state_d = StWr3;
      StWr3: begin
        if (last_q) begin
          state_d = StFinish;
          if (!at_end) error_d = 1'b1;
        end else if (at_end) begin
          fidx_d = '0;
          if (pidx_q == '1) begin
            // Segment full: every pattern slot is valid, so CYCLE stays at max.
            error_d = 1'b1;
            state_d = StFinish;
          end else begin
            pidx_d  = pidx_q + 1'b1;
            state_d = StAccept;
          end
        end else begin
          fidx_d  = fidx_q + 1'b1;
          state_d = StAccept;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output next-state, derived from the state being entered so every output is a flop.
  always_comb begin
    word_d = 2'd0;
    we_d   = 1'b1;
    unique case (state_d)
      StWr0:   word_d = 2'd0;
      StWr1:   word_d = 2'd1;
      StWr2:   word_d = 2'd2;
      StWr3:   word_d = 2'd3;
      default: we_d   = 1'b0;
    endcase

    // WR0 data is produced on the accept edge, before the focus registers load.
    if (state_q == StAccept) begin
      px = FOCUS_X; py = FOCUS_Y; pz = FOCUS_Z; pint = FOCUS_INTENSITY;
    end else begin
      px = x_q;     py = y_q;     pz = z_q;     pint = int_q;
    end

    addr_d  = MEM_ADDR;
    din_d   = MEM_DIN;
    mseg_d  = MEM_SEGMENT;
    if (we_d) begin
      addr_d = {pidx_q, fidx_q, word_d};
      din_d  = pack_focus_word(px, py, pz, pint, word_d);
      mseg_d = seg_q;
    end

    ready_d = (state_d == StAccept);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StFinish) || start_bad;
    cycle_d = (state_d == StFinish) ? pidx_q : CYCLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      seg_q       <= 1'b0;
      nfoci_q     <= '0;
      fidx_q      <= '0;
      pidx_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      int_q       <= '0;
      last_q      <= 1'b0;
      FOCUS_READY <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_SEGMENT <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_DIN     <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      CYCLE       <= '0;
      ERROR       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fidx_q      <= fidx_d;
      pidx_q      <= pidx_d;
      if (start_ok) begin
        seg_q   <= SEGMENT;
        nfoci_q <= NUM_FOCI;
      end
      if (accept) begin
        x_q    <= FOCUS_X;
        y_q    <= FOCUS_Y;
        z_q    <= FOCUS_Z;
        int_q  <= FOCUS_INTENSITY;
        last_q <= FOCUS_LAST;
      end
      FOCUS_READY <= ready_d;
      MEM_WE      <= we_d;
      MEM_SEGMENT <= mseg_d;
      MEM_ADDR    <= addr_d;
      MEM_DIN     <= din_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
      CYCLE       <= cycle_d;
      ERROR       <= error_d;
    end
  end

endmodule

// File: tb/tb_stm_focus_writer.sv
// Self-checking bench for stm_focus_writer: table of sessions driven through a
// valid/ready focus driver, with expected BRAM writes queued at acceptance and
// popped by a write monitor. Hand-written sequences cover reset and START timing.
module tb_stm_focus_writer;

  localparam int IDX_W = 13;
  localparam int FW    = 3;
  localparam int AW    = IDX_W + FW + 2;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic             SEGMENT = 1'b0;
  logic [3:0]       NUM_FOCI = 4'd0;
  logic             FOCUS_VALID = 1'b0;
  logic             FOCUS_READY;
  logic [17:0]      FOCUS_X = '0, FOCUS_Y = '0, FOCUS_Z = '0;
  logic [7:0]       FOCUS_INTENSITY = '0;
  logic             FOCUS_LAST = 1'b0;
  logic             MEM_WE, MEM_SEGMENT;
  logic [AW-1:0]    MEM_ADDR;
  logic [15:0]      MEM_DIN;
  logic             BUSY, DONE, ERROR;
  logic [IDX_W-1:0] CYCLE;

  stm_focus_writer #(.MAX_FOCI(8), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SEGMENT(SEGMENT), .NUM_FOCI(NUM_FOCI),
    .FOCUS_VALID(FOCUS_VALID), .FOCUS_READY(FOCUS_READY), .FOCUS_X(FOCUS_X),
    .FOCUS_Y(FOCUS_Y), .FOCUS_Z(FOCUS_Z), .FOCUS_INTENSITY(FOCUS_INTENSITY),
    .FOCUS_LAST(FOCUS_LAST), .MEM_WE(MEM_WE), .MEM_SEGMENT(MEM_SEGMENT),
    .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .BUSY(BUSY), .DONE(DONE), .CYCLE(CYCLE),
    .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic          seg;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic        seg;
    logic [3:0]  nf;
    int          nsend;
    int          last_at;   // index of the focus carrying LAST, -1 for none
    logic [12:0] exp_cycle;
    logic        exp_err;
    int          max_gap;
    logic        fixed;     // use the fixed single-focus test values
    logic        poke;      // raise START mid-session
  } sess_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Entry layout as a 64-bit value, sliced into 16-bit words.
  function automatic logic [15:0] model_word(input logic [17:0] x, input logic [17:0] y,
                                             input logic [17:0] z, input logic [7:0] inten,
                                             input int w);
    logic [63:0] e;
    e = {2'b00, inten, z, y, x};
    return e[16*w +: 16];
  endfunction

  task automatic push_focus(input logic seg, input logic [IDX_W-1:0] pidx,
                            input logic [FW-1:0] fidx, input logic [17:0] x,
                            input logic [17:0] y, input logic [17:0] z,
                            input logic [7:0] inten, input int nwords);
    wr_t e;
    for (int w = 0; w < nwords; w++) begin
      e.seg  = seg;
      e.addr = {pidx, fidx, w[1:0]};
      e.din  = model_word(x, y, z, inten, w);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N && MEM_WE) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, expected no write",
                 MEM_ADDR, MEM_DIN);
      end else begin
        e = exp_q.pop_front();
        check("write_seg", 32'(MEM_SEGMENT), 32'(e.seg));
        check("write_addr", 32'(MEM_ADDR), 32'(e.addr));
        check("write_data", 32'(MEM_DIN), 32'(e.din));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(FOCUS_READY), 32'd0);
    check({tag, "_we"}, 32'(MEM_WE), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_error"}, 32'(ERROR), 32'd0);
    check({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
    check({tag, "_din"}, 32'(MEM_DIN), 32'd0);
    check({tag, "_mseg"}, 32'(MEM_SEGMENT), 32'd0);
    check({tag, "_cycle"}, 32'(CYCLE), 32'd0);
  endtask

  task automatic run_session(input sess_t s);
    logic             legal;
    logic [IDX_W-1:0] pidx;
    logic [FW-1:0]    fidx;
    logic [17:0]      x, y, z;
    logic [7:0]       inten;
    int               gap, n, prev_acc;
    legal = (s.nf != 4'd0) && (s.nf <= 4'd8);
    pidx = '0;
    fidx = '0;
    prev_acc = 0;
    @(negedge CLK);
    START = 1'b1; SEGMENT = s.seg; NUM_FOCI = s.nf;
    @(posedge CLK);
    #1 START = 1'b0;
    for (int i = 0; i < s.nsend; i++) begin
      @(negedge CLK);
      check("ready_high", 32'(FOCUS_READY), 32'd1);
      gap = (s.max_gap > 0) ? int'($urandom_range(s.max_gap, 0)) : 0;
      repeat (gap) @(negedge CLK);
      x     = s.fixed ? 18'h1FFFF : 18'($urandom);
      y     = s.fixed ? 18'h3FFFF : 18'($urandom);
      z     = s.fixed ? 18'h00123 : 18'($urandom);
      inten = s.fixed ? 8'hA5 : 8'($urandom);
      FOCUS_VALID = 1'b1; FOCUS_X = x; FOCUS_Y = y; FOCUS_Z = z;
      FOCUS_INTENSITY = inten; FOCUS_LAST = (i == s.last_at);
      if (s.poke && i == 1) begin
        START = 1'b1; SEGMENT = ~s.seg; NUM_FOCI = 4'd0;
      end
      n = 0;
      while (!FOCUS_READY && n < 20) begin
        @(negedge CLK);
        n++;
      end
      if (!FOCUS_READY) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got FOCUS_READY=0 for 20 cycles, expected 1");
        FOCUS_VALID = 1'b0;
        START = 1'b0;
        return;
      end
      if (i > 0 && gap == 0) check("accept_period", 32'(cyc - prev_acc), 32'd5);
      prev_acc = cyc;
      push_focus(s.seg, pidx, fidx, x, y, z, inten, 4);
      if (32'(fidx) == 32'(s.nf) - 1) begin
        fidx = '0;
        pidx = pidx + 1'b1;
      end else begin
        fidx = fidx + 1'b1;
      end
      @(posedge CLK);
      #1 FOCUS_VALID = 1'b0; FOCUS_LAST = 1'b0; START = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge CLK);
        check("ready_low", 32'(FOCUS_READY), 32'd0);
      end
    end
    n = 0;
    @(negedge CLK);
    while (!DONE && n < 12) begin
      @(negedge CLK);
      n++;
    end
    check("done", 32'(DONE), 32'd1);
    check("error", 32'(ERROR), 32'(s.exp_err));
    check("busy_at_done", 32'(BUSY), 32'(legal));
    if (legal) check("cycle", 32'(CYCLE), 32'(s.exp_cycle));
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
    check("done_pulse", 32'(DONE), 32'd0);
    check("busy_after", 32'(BUSY), 32'd0);
  endtask

  sess_t tbl[8];
  sess_t s;

  initial begin
    //        seg   nf    nsend last cycle  err   gap fixed poke
    tbl[0] = '{1'b1, 4'd1, 1,  0,  13'd0, 1'b0, 0, 1'b1, 1'b0};  // single focus
    tbl[1] = '{1'b0, 4'd3, 12, 11, 13'd3, 1'b0, 0, 1'b0, 1'b0};  // multi-focus patterns
    tbl[2] = '{1'b1, 4'd2, 10, 9,  13'd4, 1'b0, 3, 1'b0, 1'b0};  // valid gaps
    tbl[3] = '{1'b0, 4'd4, 6,  5,  13'd1, 1'b1, 1, 1'b0, 1'b0};  // LAST mid-pattern
    tbl[4] = '{1'b0, 4'd0, 0,  -1, 13'd0, 1'b1, 0, 1'b0, 1'b0};  // illegal 0
    tbl[5] = '{1'b1, 4'd9, 0,  -1, 13'd0, 1'b1, 0, 1'b0, 1'b0};  // illegal 9
    tbl[6] = '{1'b1, 4'd8, 16, 15, 13'd1, 1'b0, 2, 1'b0, 1'b0};  // MAX_FOCI, clears ERROR
    tbl[7] = '{1'b0, 4'd2, 4,  3,  13'd1, 1'b0, 0, 1'b0, 1'b1};  // START while BUSY

    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) run_session(tbl[i]);

    // Reset during WR1: the two words already written stay, nothing follows.
    @(negedge CLK);
    START = 1'b1; SEGMENT = 1'b1; NUM_FOCI = 4'd2;
    @(posedge CLK);
    #1 START = 1'b0;
    @(negedge CLK);
    FOCUS_VALID = 1'b1; FOCUS_X = 18'h2AAAA; FOCUS_Y = 18'h15555;
    FOCUS_Z = 18'h0F0F0; FOCUS_INTENSITY = 8'h3C; FOCUS_LAST = 1'b0;
    check("rst_seq_ready", 32'(FOCUS_READY), 32'd1);
    push_focus(1'b1, '0, '0, 18'h2AAAA, 18'h15555, 18'h0F0F0, 8'h3C, 2);
    @(posedge CLK);
    #1 FOCUS_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_seq_wr1", 32'(MEM_WE), 32'd1);
    #1 RST_N = 1'b0;
    #1 check_reset_outputs("midreset");
    check("midreset_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("post_reset_idle", 32'(BUSY), 32'd0);

    s = '{1'b0, 4'd1, 3, 2, 13'd2, 1'b0, 1, 1'b0, 1'b0};
    run_session(s);

    // Fill every pattern slot without LAST: overflow ends the session.
    s = '{1'b1, 4'd1, 8192, -1, 13'd8191, 1'b1, 0, 1'b0, 1'b0};
    run_session(s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
